// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipelined controller: opcodes, ALU ops, operand selects,
// branch funct3 codes, result-source codes and the mul/div sequencer state type.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_R      = 7'b0110011;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] SRCA_RS1  = 2'd0;
    localparam logic [1:0] SRCA_PC   = 2'd1;
    localparam logic [1:0] SRCA_ZERO = 2'd2;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_BUSY = 1'b1
    } seqState_t;

    // Fixed-width control fields carried down the pipe (ALU control travels separately).
    typedef struct packed {
        logic       regWrite;
        logic [1:0] resultSrc;
        logic       memWrite;
        logic       jump;
        logic       branch;
        logic [1:0] aluSrcA;
        logic       aluSrcB;
        logic [2:0] funct3;
    } ctrlBundle_t;

    // alt selects SUB over ADD for funct3 000 and SRA over SRL for funct3 101.
    function automatic logic [3:0] aluDecode(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipelined_controller_muldiv_seq.sv
// Mul/div E-stage occupancy sequencer: keeps a multicycle op parked in E for its latency.
module muldiv_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 2,
    parameter int DIV_LATENCY = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic start,
    input  logic isDiv,
    output logic busy
);

    localparam int CNT_W = $clog2(maxInt(maxInt(MUL_LATENCY, DIV_LATENCY), 2));
    localparam logic [CNT_W-1:0] MUL_LOAD = (MUL_LATENCY > 1) ? CNT_W'(MUL_LATENCY - 2) : '0;
    localparam logic [CNT_W-1:0] DIV_LOAD = (DIV_LATENCY > 1) ? CNT_W'(DIV_LATENCY - 2) : '0;
    localparam logic MUL_MULTI = (MUL_LATENCY > 1);
    localparam logic DIV_MULTI = (DIV_LATENCY > 1);

    seqState_t        state_reg;
    logic [CNT_W-1:0] count_reg;
    logic             launch;

    assign launch = (state_reg == SEQ_IDLE) && start && (isDiv ? DIV_MULTI : MUL_MULTI);

    // BUSY with an exhausted counter is the op's final E cycle, so E is released there.
    assign busy = launch || ((state_reg == SEQ_BUSY) && (count_reg != '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= SEQ_IDLE;
            count_reg <= '0;
        end else if (flush) begin
            state_reg <= SEQ_IDLE;
            count_reg <= '0;
        end else begin
            case (state_reg)
                SEQ_IDLE: begin
                    if (launch) begin
                        state_reg <= SEQ_BUSY;
                        count_reg <= isDiv ? DIV_LOAD : MUL_LOAD;
                    end
                end
                SEQ_BUSY: begin
                    if (count_reg == '0) begin
                        state_reg <= SEQ_IDLE;
                    end else begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= SEQ_IDLE;
                    count_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipelined_controller.sv
// RV32I pipeline controller: D decode, E/M/W control registers and branch resolution.
// Define MULDIV_EXT_EN to build the multicycle mul/div sequencer.
module pipelined_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W   = 4,
    parameter int MUL_LATENCY = 2,
    parameter int DIV_LATENCY = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opD,
    input  logic [2:0]           funct3D,
    input  logic [6:0]           funct7D,
    output logic [2:0]           ImmSrcD,
    input  logic                 FlushE,
    input  logic                 ZeroE,
    input  logic                 LtE,
    input  logic                 LtuE,
    output logic                 PCSrcE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic [1:0]           ALUSrcAE,
    output logic                 ALUSrcBE,
    output logic                 ResultSrcEb0,
    output logic                 MulDivBusyE,
    output logic [2:0]           MulDivOpE,
    output logic                 MemWriteM,
    output logic [2:0]           MemWidthM,
    output logic                 RegWriteM,
    output logic                 RegWriteW,
    output logic [1:0]           ResultSrcW
);

    ctrlBundle_t ctrlD;
    logic [3:0]  aluCtrlD;
    logic        knownD;

    ctrlBundle_t ctrlE_reg;
    logic [3:0]  aluCtrlE_reg;
    logic        mulDivBusy;
    logic        branchTaken;

    logic        regWriteM_reg;
    logic        memWriteM_reg;
    logic [2:0]  memWidthM_reg;
    logic [1:0]  resultSrcM_reg;
    logic        regWriteW_reg;
    logic [1:0]  resultSrcW_reg;

    always_comb begin
        ctrlD    = '0;
        aluCtrlD = ALU_ADD;
        ImmSrcD  = IMM_I;
        knownD   = 1'b1;
        case (opD)
            OP_LUI: begin
                ctrlD.regWrite = 1'b1;
                ctrlD.aluSrcA  = SRCA_ZERO;
                ctrlD.aluSrcB  = 1'b1;
                ImmSrcD        = IMM_U;
            end
            OP_AUIPC: begin
                ctrlD.regWrite = 1'b1;
                ctrlD.aluSrcA  = SRCA_PC;
                ctrlD.aluSrcB  = 1'b1;
                ImmSrcD        = IMM_U;
            end
            OP_JAL: begin
                ctrlD.regWrite  = 1'b1;
                ctrlD.resultSrc = RES_PC4;
                ctrlD.jump      = 1'b1;
                ctrlD.aluSrcA   = SRCA_PC;
                ctrlD.aluSrcB   = 1'b1;
                ImmSrcD         = IMM_J;
            end
            OP_JALR: begin
                ctrlD.regWrite  = 1'b1;
                ctrlD.resultSrc = RES_PC4;
                ctrlD.jump      = 1'b1;
                ctrlD.aluSrcB   = 1'b1;
            end
            OP_BRANCH: begin
                ctrlD.branch = 1'b1;
                aluCtrlD     = ALU_SUB;
                ImmSrcD      = IMM_B;
            end
            OP_LOAD: begin
                ctrlD.regWrite  = 1'b1;
                ctrlD.resultSrc = RES_MEM;
                ctrlD.aluSrcB   = 1'b1;
            end
            OP_STORE: begin
                ctrlD.memWrite = 1'b1;
                ctrlD.aluSrcB  = 1'b1;
                ImmSrcD        = IMM_S;
            end
            OP_IMM: begin
                ctrlD.regWrite = 1'b1;
                ctrlD.aluSrcB  = 1'b1;
                aluCtrlD       = aluDecode(funct3D, (funct3D == 3'b101) && funct7D[5]);
            end
            OP_R: begin
                ctrlD.regWrite = 1'b1;
                aluCtrlD       = aluDecode(funct3D, funct7D[5]);
            end
            default: knownD = 1'b0;
        endcase
        // Unknown opcodes must not leak funct3 into MemWidthM or the branch condition.
        ctrlD.funct3 = knownD ? funct3D : 3'b000;
    end

    // Flush beats the multicycle hold so a redirect always empties E.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrlE_reg    <= '0;
            aluCtrlE_reg <= '0;
        end else if (FlushE) begin
            ctrlE_reg    <= '0;
            aluCtrlE_reg <= '0;
        end else if (!mulDivBusy) begin
            ctrlE_reg    <= ctrlD;
            aluCtrlE_reg <= aluCtrlD;
        end
    end

`ifdef MULDIV_EXT_EN
    logic mulDivD;
    logic mulDivE_reg;

    assign mulDivD = (opD == OP_R) && (funct7D == F7_MULDIV);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mulDivE_reg <= 1'b0;
        end else if (FlushE) begin
            mulDivE_reg <= 1'b0;
        end else if (!mulDivBusy) begin
            mulDivE_reg <= mulDivD;
        end
    end

    muldiv_seq #(
        .MUL_LATENCY(MUL_LATENCY),
        .DIV_LATENCY(DIV_LATENCY)
    ) uSeq (
        .clk  (clk),
        .reset(reset),
        .flush(FlushE),
        .start(mulDivE_reg),
        .isDiv(ctrlE_reg.funct3[2]),
        .busy (mulDivBusy)
    );

    assign MulDivOpE = mulDivE_reg ? ctrlE_reg.funct3 : 3'b000;
`else
    localparam int unusedLatency = MUL_LATENCY + DIV_LATENCY;
    logic unusedFunct7;

    assign unusedFunct7 = ^{funct7D[6], funct7D[4:0]};
    assign mulDivBusy   = 1'b0;
    assign MulDivOpE    = 3'b000;
`endif

    always_comb begin
        case (ctrlE_reg.funct3)
            BR_BEQ:  branchTaken = ZeroE;
            BR_BNE:  branchTaken = !ZeroE;
            BR_BLT:  branchTaken = LtE;
            BR_BGE:  branchTaken = !LtE;
            BR_BLTU: branchTaken = LtuE;
            BR_BGEU: branchTaken = !LtuE;
            default: branchTaken = 1'b0;
        endcase
    end

    assign PCSrcE       = (ctrlE_reg.branch && branchTaken) || ctrlE_reg.jump;
    assign ALUControlE  = ALUCTRL_W'(aluCtrlE_reg);
    assign ALUSrcAE     = ctrlE_reg.aluSrcA;
    assign ALUSrcBE     = ctrlE_reg.aluSrcB;
    assign ResultSrcEb0 = ctrlE_reg.resultSrc[0];
    assign MulDivBusyE  = mulDivBusy;

    // A held multicycle op sends bubbles to M until its final E cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regWriteM_reg  <= 1'b0;
            memWriteM_reg  <= 1'b0;
            memWidthM_reg  <= 3'b000;
            resultSrcM_reg <= RES_ALU;
            regWriteW_reg  <= 1'b0;
            resultSrcW_reg <= RES_ALU;
        end else begin
            regWriteM_reg  <= ctrlE_reg.regWrite && !mulDivBusy;
            memWriteM_reg  <= ctrlE_reg.memWrite && !mulDivBusy;
            memWidthM_reg  <= ctrlE_reg.funct3;
            resultSrcM_reg <= ctrlE_reg.resultSrc;
            regWriteW_reg  <= regWriteM_reg;
            resultSrcW_reg <= resultSrcM_reg;
        end
    end

    assign MemWriteM  = memWriteM_reg;
    assign MemWidthM  = memWidthM_reg;
    assign RegWriteM  = regWriteM_reg;
    assign RegWriteW  = regWriteW_reg;
    assign ResultSrcW = resultSrcW_reg;

endmodule

// File: tb/tb_pipelined_controller.sv
// Bench for pipelined_controller: directed pipeline scenarios plus random instruction
// streams checked against an instruction-level reference of the E/M/W control stages.
module tb_pipelined_controller;
    import pipe_ctrl_pkg::*;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 32;
    localparam logic [6:0] NOP_OP = 7'b0000000;
    localparam logic [6:0] OPS [10] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                                        OP_LOAD, OP_STORE, OP_IMM, OP_R, 7'b1111111};

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opD;
    logic [2:0] funct3D;
    logic [6:0] funct7D;
    logic [2:0] ImmSrcD;
    logic       FlushE, ZeroE, LtE, LtuE;
    logic       PCSrcE;
    logic [3:0] ALUControlE;
    logic [1:0] ALUSrcAE;
    logic       ALUSrcBE, ResultSrcEb0, MulDivBusyE;
    logic [2:0] MulDivOpE;
    logic       MemWriteM;
    logic [2:0] MemWidthM;
    logic       RegWriteM, RegWriteW;
    logic [1:0] ResultSrcW;

    pipelined_controller #(
        .ALUCTRL_W(4), .MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT)
    ) dut (
        .clk(clk), .reset(reset), .opD(opD), .funct3D(funct3D), .funct7D(funct7D),
        .ImmSrcD(ImmSrcD), .FlushE(FlushE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
        .PCSrcE(PCSrcE), .ALUControlE(ALUControlE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
        .ResultSrcEb0(ResultSrcEb0), .MulDivBusyE(MulDivBusyE), .MulDivOpE(MulDivOpE),
        .MemWriteM(MemWriteM), .MemWidthM(MemWidthM), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rw;
        logic [1:0] rs;
        logic       mw;
        logic       jmp;
        logic       br;
        logic [3:0] alu;
        logic [1:0] sa;
        logic       sb;
        logic [2:0] imm;
        logic [2:0] f3;
    } ctl_t;

    ctl_t eE, eM, eW;
    int   errors = 0;
    int   checks = 0;
    int   busyCount;

    // Architectural meaning of each instruction class, one row per opcode.
    function automatic ctl_t refDecode(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
        ctl_t c = '0;
        logic [3:0] aluTbl [8];
        aluTbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        c.f3 = f3;
        case (op)
            OP_LUI:    begin c.rw = 1; c.sa = SRCA_ZERO; c.sb = 1; c.imm = IMM_U; end
            OP_AUIPC:  begin c.rw = 1; c.sa = SRCA_PC;   c.sb = 1; c.imm = IMM_U; end
            OP_JAL:    begin c.rw = 1; c.rs = RES_PC4; c.jmp = 1; c.sa = SRCA_PC; c.sb = 1; c.imm = IMM_J; end
            OP_JALR:   begin c.rw = 1; c.rs = RES_PC4; c.jmp = 1; c.sb = 1; c.imm = IMM_I; end
            OP_BRANCH: begin c.br = 1; c.alu = ALU_SUB; c.imm = IMM_B; end
            OP_LOAD:   begin c.rw = 1; c.rs = RES_MEM; c.sb = 1; c.imm = IMM_I; end
            OP_STORE:  begin c.mw = 1; c.sb = 1; c.imm = IMM_S; end
            OP_IMM: begin
                c.rw = 1; c.sb = 1;
                c.alu = (f3 == 3'b101 && f7[5]) ? ALU_SRA : aluTbl[f3];
            end
            OP_R: begin
                c.rw = 1;
                c.alu = aluTbl[f3];
                if (f7[5] && f3 == 3'b000) c.alu = ALU_SUB;
                if (f7[5] && f3 == 3'b101) c.alu = ALU_SRA;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic refPcSrc(ctl_t e);
        logic cond;
        case (e.f3)
            3'b000:  cond = ZeroE;
            3'b001:  cond = !ZeroE;
            3'b100:  cond = LtE;
            3'b101:  cond = !LtE;
            3'b110:  cond = LtuE;
            3'b111:  cond = !LtuE;
            default: cond = 1'b0;
        endcase
        return (e.br && cond) || e.jmp;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        ctl_t d;
        d = refDecode(opD, funct3D, funct7D);
        chk("ImmSrcD", 32'(ImmSrcD), 32'(d.imm));
        chk("PCSrcE", 32'(PCSrcE), 32'(refPcSrc(eE)));
        chk("ALUControlE", 32'(ALUControlE), 32'(eE.alu));
        chk("ALUSrcAE", 32'(ALUSrcAE), 32'(eE.sa));
        chk("ALUSrcBE", 32'(ALUSrcBE), 32'(eE.sb));
        chk("ResultSrcEb0", 32'(ResultSrcEb0), 32'(eE.rs[0]));
        chk("MemWriteM", 32'(MemWriteM), 32'(eM.mw));
        chk("MemWidthM", 32'(MemWidthM), 32'(eM.f3));
        chk("RegWriteM", 32'(RegWriteM), 32'(eM.rw));
        chk("RegWriteW", 32'(RegWriteW), 32'(eW.rw));
        chk("ResultSrcW", 32'(ResultSrcW), 32'(eW.rs));
        chk("MulDivBusyE", 32'(MulDivBusyE), 32'd0);
        chk("MulDivOpE", 32'(MulDivOpE), 32'd0);
    endtask

    // One clock with the reference pipeline advanced alongside, then a full check.
    task automatic cycle();
        @(posedge clk);
        if (reset) begin
            eE = '0; eM = '0; eW = '0;
        end else begin
            eW = eM;
            eM = eE;
            eE = FlushE ? '0 : refDecode(opD, funct3D, funct7D);
        end
        @(negedge clk);
        checkAll();
    endtask

    task automatic rawCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic setD(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opD = op; funct3D = f3; funct7D = f7;
    endtask

    task automatic asyncResetCheck(input string tag);
        #2 reset = 1'b1;
        #1;
        $display("async reset during %s", tag);
        chk("rst_PCSrcE", 32'(PCSrcE), 32'd0);
        chk("rst_ALUControlE", 32'(ALUControlE), 32'd0);
        chk("rst_ALUSrcAE", 32'(ALUSrcAE), 32'd0);
        chk("rst_ALUSrcBE", 32'(ALUSrcBE), 32'd0);
        chk("rst_ResultSrcEb0", 32'(ResultSrcEb0), 32'd0);
        chk("rst_MulDivBusyE", 32'(MulDivBusyE), 32'd0);
        chk("rst_MulDivOpE", 32'(MulDivOpE), 32'd0);
        chk("rst_MemWriteM", 32'(MemWriteM), 32'd0);
        chk("rst_MemWidthM", 32'(MemWidthM), 32'd0);
        chk("rst_RegWriteM", 32'(RegWriteM), 32'd0);
        chk("rst_RegWriteW", 32'(RegWriteW), 32'd0);
        chk("rst_ResultSrcW", 32'(ResultSrcW), 32'd0);
        eE = '0; eM = '0; eW = '0;
        cycle();
        reset = 1'b0;
        setD(NOP_OP, 3'b000, 7'b0);
        repeat (3) cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; FlushE = 0; ZeroE = 0; LtE = 0; LtuE = 0;
        setD(NOP_OP, 3'b000, 7'b0);
        eE = '0; eM = '0; eW = '0;
        @(negedge clk); @(negedge clk);
        $display("reset state");
        checkAll();
        reset = 1'b0;

        // beq taken with ZeroE; bgeu not taken when LtuE
        setD(OP_BRANCH, BR_BEQ, 7'b0);
        cycle();
        ZeroE = 1; setD(OP_BRANCH, BR_BGEU, 7'b0);
        #1 chk("beq_taken", 32'(PCSrcE), 32'd1);
        $display("beq in E, ZeroE=1, PCSrcE=%0b", PCSrcE);
        cycle();
        ZeroE = 0; LtuE = 1; setD(NOP_OP, 3'b000, 7'b0);
        #1 chk("bgeu_not_taken", 32'(PCSrcE), 32'd0);
        LtuE = 0;
        #1 chk("bgeu_taken", 32'(PCSrcE), 32'd1);
        $display("bgeu in E, LtuE=0, PCSrcE=%0b", PCSrcE);

        // lw latency through E, M, W
        setD(OP_LOAD, 3'b010, 7'b0);
        cycle();
        setD(NOP_OP, 3'b000, 7'b0);
        chk("lw_ResultSrcEb0", 32'(ResultSrcEb0), 32'd1);
        cycle();
        chk("lw_MemWidthM", 32'(MemWidthM), 32'd2);
        cycle();
        chk("lw_ResultSrcW", 32'(ResultSrcW), 32'd1);
        chk("lw_RegWriteW", 32'(RegWriteW), 32'd1);
        $display("lw reached W: ResultSrcW=%0d RegWriteW=%0b", ResultSrcW, RegWriteW);

        // sw flushed on capture never writes memory; an unflushed sh does
        setD(OP_STORE, 3'b010, 7'b0); FlushE = 1;
        cycle();
        FlushE = 0; setD(NOP_OP, 3'b000, 7'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("sw_flushed_MemWriteM", 32'(MemWriteM), 32'd0);
        end
        setD(OP_STORE, 3'b001, 7'b0);
        cycle();
        setD(NOP_OP, 3'b000, 7'b0);
        cycle();
        chk("sh_MemWriteM", 32'(MemWriteM), 32'd1);
        chk("sh_MemWidthM", 32'(MemWidthM), 32'd1);
        $display("sw flushed / sh stored: MemWriteM=%0b", MemWriteM);

`ifndef MULDIV_EXT_EN
        // mul encoding is an ordinary R-type add
        setD(OP_R, 3'b000, F7_MULDIV);
        cycle();
        setD(NOP_OP, 3'b000, 7'b0);
        chk("mul_busy", 32'(MulDivBusyE), 32'd0);
        cycle();
        cycle();
        chk("mul_RegWriteW", 32'(RegWriteW), 32'd1);
        $display("mul without extension: RegWriteW=%0b", RegWriteW);
`else
        // mulh, latency 2: one busy cycle, then writes back
        setD(OP_R, 3'b001, F7_MULDIV);
        rawCycle();
        setD(NOP_OP, 3'b000, 7'b0);
        chk("mul_busy", 32'(MulDivBusyE), 32'd1);
        chk("mul_op", 32'(MulDivOpE), 32'd1);
        rawCycle();
        chk("mul_busy_end", 32'(MulDivBusyE), 32'd0);
        chk("mul_bubble_RegWriteM", 32'(RegWriteM), 32'd0);
        rawCycle();
        chk("mul_RegWriteM", 32'(RegWriteM), 32'd1);
        $display("mulh done: RegWriteM=%0b", RegWriteM);

        // div: DIV_LAT-1 busy cycles with bubbles, then writes back
        setD(OP_R, 3'b100, F7_MULDIV);
        rawCycle();
        setD(NOP_OP, 3'b000, 7'b0);
        busyCount = 0;
        for (int n = 0; n < 64 && MulDivBusyE === 1'b1; n++) begin
            busyCount++;
            chk("div_busy_RegWriteM", 32'(RegWriteM), 32'd0);
            chk("div_busy_op", 32'(MulDivOpE), 32'd4);
            rawCycle();
        end
        chk("div_busy_cycles", 32'(busyCount), 32'(DIV_LAT - 1));
        chk("div_final_RegWriteM", 32'(RegWriteM), 32'd0);
        rawCycle();
        chk("div_RegWriteM", 32'(RegWriteM), 32'd1);
        $display("div busy for %0d cycles then RegWriteM=%0b", busyCount, RegWriteM);

        // rem flushed at busy cycle 5: abandoned, no writeback
        setD(OP_R, 3'b110, F7_MULDIV);
        rawCycle();
        setD(NOP_OP, 3'b000, 7'b0);
        repeat (4) rawCycle();
        chk("flush_pre_busy", 32'(MulDivBusyE), 32'd1);
        FlushE = 1;
        rawCycle();
        FlushE = 0;
        chk("flush_busy_cleared", 32'(MulDivBusyE), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("flush_RegWriteM", 32'(RegWriteM), 32'd0);
            chk("flush_RegWriteW", 32'(RegWriteW), 32'd0);
            rawCycle();
        end
        $display("rem flushed at busy cycle 5: MulDivBusyE=%0b", MulDivBusyE);
        eE = '0; eM = '0; eW = '0;
`endif

        // random instruction stream against the reference pipeline
        for (int i = 0; i < 300; i++) begin
            setD(OPS[$urandom_range(0, 9)], 3'($urandom), 7'b0);
            case ($urandom_range(0, 3))
                0: funct7D = 7'b0000000;
                1: funct7D = 7'b0100000;
                2: funct7D = 7'($urandom);
                default: funct7D = F7_MULDIV;
            endcase
`ifdef MULDIV_EXT_EN
            if (opD == OP_R && funct7D == F7_MULDIV) funct7D = 7'b0000000;
`endif
            FlushE = ($urandom_range(0, 9) == 0);
            ZeroE = 1'($urandom); LtE = 1'($urandom); LtuE = 1'($urandom);
            cycle();
        end
        FlushE = 0; ZeroE = 0; LtE = 0; LtuE = 0;
        $display("random stream done, checks so far %0d", checks);

`ifdef MULDIV_EXT_EN
        setD(OP_R, 3'b101, F7_MULDIV);
        rawCycle();
        setD(NOP_OP, 3'b000, 7'b0);
        repeat (3) rawCycle();
        chk("middiv_busy", 32'(MulDivBusyE), 32'd1);
        asyncResetCheck("divu");
`else
        setD(OP_LOAD, 3'b010, 7'b0);
        cycle();
        setD(OP_JAL, 3'b000, 7'b0);
        cycle();
        chk("prereset_RegWriteM", 32'(RegWriteM), 32'd1);
        chk("prereset_PCSrcE", 32'(PCSrcE), 32'd1);
        asyncResetCheck("lw/jal in flight");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
